seq_detect_prog: RTL and testbench

Programmable serial bit-pattern detector. It is the parametrised successor to the team's fixed four-bit Mealy sequence detectors. The pattern, its length (1..MAX_LEN) and the overlap mode are loaded at run time through a config port. A valid-qualified serial input stream is matched against the pattern, and the block flags matches combinationally and with a registered copy. It also keeps a saturating match counter. It sits between a serial front end and control logic that needs frame-marker or sync-word detection.

---
 rtl/seq_detect_prog.sv | 114 +++++++++++
 tb/tb_seq_detect_prog.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with run-time pattern, length and
// overlap mode, Mealy match flag, registered copy and saturating match counter.
module seq_detect_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_q,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic [1:0] {
    DISABLED,
    FILLING,
    HUNTING
  } state_t;

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [LEN_W-1:0]   len_m1;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               cfg_ok;
  state_t             st;

  assign len_m1 = len - LEN_W'(1);
  assign win    = {hist, x};
  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // Only the low len bits of the window and pattern take part in a match.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign hit = (((win ^ pat) & mask) == '0);

  always_comb begin
    st = DISABLED;
    if (armed) begin
      st = (fill == len_m1) ? HUNTING : FILLING;
    end
  end

  assign z = (st == HUNTING) & x_valid & ~cfg_we & hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat         <= '0;
      len         <= '0;
      ovl         <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      armed       <= 1'b0;
      cfg_err     <= 1'b0;
      z_q         <= 1'b0;
      match_count <= '0;
    end else begin
      z_q <= z;

      if (cnt_clr) begin
        match_count <= '0;
      end else if (z && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end

      if (cfg_we) begin
        hist <= '0;
        fill <= '0;
        if (cfg_ok) begin
          pat     <= cfg_pattern;
          len     <= cfg_len;
          ovl     <= cfg_overlap;
          armed   <= 1'b1;
          cfg_err <= 1'b0;
        end else begin
          pat     <= '0;
          len     <= '0;
          ovl     <= 1'b0;
          armed   <= 1'b0;
          cfg_err <= 1'b1;
        end
      end else if (armed && x_valid) begin
        hist <= win[MAX_LEN-2:0];
        // A non-overlapping match consumes the pattern bits.
        if (z && !ovl) begin
          fill <= '0;
        end else if (st == FILLING) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised and directed bench for seq_detect_prog against a bit-queue
// reference model; a second instance with a 2-bit counter checks saturation.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       z, z_q, armed, cfg_err;
  logic [7:0] match_count;
  logic       z2, zq2, armed2, err2;
  logic [1:0] cnt2;

  int total = 0;
  int bad = 0;

  logic       obs_z, obs_z2, obs_zq, obs_zq2, obs_armed, obs_err;
  logic       obs_armed2, obs_err2;
  logic [7:0] obs_cnt;
  logic [1:0] obs_cnt2;
  bit         exp_z;

  bit         m_armed, m_err, m_ovl, m_zq;
  bit [7:0]   m_pat;
  int         m_len, m_start, m_cnt, m_cnt2;
  bit         q[$];

  seq_detect_prog dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .x(x), .x_valid(x_valid),
    .cnt_clr(cnt_clr), .z(z), .z_q(z_q), .armed(armed),
    .cfg_err(cfg_err), .match_count(match_count)
  );

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .x(x), .x_valid(x_valid),
    .cnt_clr(cnt_clr), .z(z2), .z_q(zq2), .armed(armed2),
    .cfg_err(err2), .match_count(cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  // A match needs len bits accepted since the last consuming match, the
  // newest being x, equal to the pattern read last-bit-first.
  function automatic bit model_z(bit xb, bit v, bit we);
    if (!m_armed || !v || we) return 1'b0;
    if (q.size() - m_start + 1 < m_len) return 1'b0;
    if (xb != m_pat[0]) return 1'b0;
    for (int j = 1; j < m_len; j++) begin
      if (q[q.size() - j] != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_armed = 0; m_err = 0; m_ovl = 0; m_zq = 0;
    m_pat = 0; m_len = 0; m_start = 0; m_cnt = 0; m_cnt2 = 0;
    q.delete();
  endfunction

  function automatic void model_step(bit xb, bit v, bit we, bit clr);
    m_zq = exp_z;
    if (clr) begin
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (exp_z) begin
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
      m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
    end
    if (we) begin
      q.delete();
      m_start = 0;
      if (cfg_len >= 1 && cfg_len <= 8) begin
        m_armed = 1; m_err = 0;
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      end else begin
        m_armed = 0; m_err = 1;
        m_pat = 0; m_len = 0; m_ovl = 0;
      end
    end else if (m_armed && v) begin
      q.push_back(xb);
      if (exp_z && !m_ovl) m_start = q.size();
    end
  endfunction

  task automatic drive(input logic xb, input logic v,
                       input logic we, input logic clr);
    @(negedge clk);
    x = xb; x_valid = v; cfg_we = we; cnt_clr = clr;
    #1;
    obs_z = z;
    obs_z2 = z2;
    exp_z = model_z(xb, v, we);
    @(posedge clk);
    model_step(xb, v, we, clr);
    #1;
    obs_zq = z_q; obs_zq2 = zq2;
    obs_cnt = match_count; obs_cnt2 = cnt2;
    obs_armed = armed; obs_err = cfg_err;
    obs_armed2 = armed2; obs_err2 = err2;
    x_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l,
                      input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    drive(1'($urandom % 2), 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    x = 1'b1; x_valid = 1'b1;
    #1;
    total++;
    if ({z, z_q, armed, cfg_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {z, z_q, armed, cfg_err});
    end
    total++;
    if (match_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", match_count);
    end
    reset = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_z !== 1'b0 || obs_armed !== 1'b0) begin
      bad++;
      $display("FAIL disabled z=%b armed=%b want 0 0", obs_z, obs_armed);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    logic w;
    s = 7'b0110110;
    load(8'b0110, 4'd4, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      w = (i == 3 || i == 6);
      drive(s[6-i], 1'b1, 1'b0, 1'b0);
      total++;
      if (obs_z !== w) begin
        bad++;
        $display("FAIL ovl_z bit%0d got=%b want=%b", i + 1, obs_z, w);
      end
      total++;
      if (obs_zq !== w) begin
        bad++;
        $display("FAIL ovl_zq bit%0d got=%b want=%b", i + 1, obs_zq, w);
      end
    end
    total++;
    if (obs_cnt !== 8'd2) begin
      bad++;
      $display("FAIL ovl_count got=%0d want=2", obs_cnt);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s;
    logic w;
    s = 7'b0110110;
    load(8'b0110, 4'd4, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      w = (i == 3);
      drive(s[6-i], 1'b1, 1'b0, 1'b0);
      total++;
      if (obs_z !== w) begin
        bad++;
        $display("FAIL novl_z bit%0d got=%b want=%b", i + 1, obs_z, w);
      end
    end
    total++;
    if (obs_cnt !== 8'd1) begin
      bad++;
      $display("FAIL novl_count got=%0d want=1", obs_cnt);
    end
    load(8'b11, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = (i == 1 || i == 3);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (obs_z !== w) begin
        bad++;
        $display("FAIL novl11_z bit%0d got=%b want=%b", i + 1, obs_z, w);
      end
    end
  endtask

  task automatic test_len_bounds();
    logic [3:0] xs, vs;
    logic w;
    xs = 4'b1101;
    vs = 4'b1011;
    load(8'b1, 4'd1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w = xs[3-i] & vs[3-i];
      drive(xs[3-i], vs[3-i], 1'b0, 1'b0);
      total++;
      if (obs_z !== w) begin
        bad++;
        $display("FAIL len1_z step%0d got=%b want=%b", i, obs_z, w);
      end
    end
    total++;
    if (obs_cnt !== 8'd2) begin
      bad++;
      $display("FAIL len1_count got=%0d want=2", obs_cnt);
    end
    load(8'hFF, 4'd8, 1'b1);
    for (int i = 0; i < 9; i++) begin
      w = (i >= 7);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (obs_z !== w) begin
        bad++;
        $display("FAIL len8_z bit%0d got=%b want=%b", i + 1, obs_z, w);
      end
    end
  endtask

  task automatic test_bad_cfg();
    logic [3:0] lens [2];
    lens[0] = 4'd0;
    lens[1] = 4'd9;
    load(8'b11, 4'd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      load(8'hFF, lens[k], 1'b1);
      total++;
      if (obs_err !== 1'b1 || obs_armed !== 1'b0) begin
        bad++;
        $display("FAIL badcfg len=%0d err=%b armed=%b want 1 0",
                 lens[k], obs_err, obs_armed);
      end
      for (int i = 0; i < 8; i++) begin
        drive(1'($urandom % 2), 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_z !== 1'b0) begin
          bad++;
          $display("FAIL badcfg_z len=%0d got=%b want=0", lens[k], obs_z);
        end
      end
    end
    load(8'b101, 4'd3, 1'b0);
    total++;
    if (obs_err !== 1'b0 || obs_armed !== 1'b1) begin
      bad++;
      $display("FAIL goodcfg err=%b armed=%b want 0 1", obs_err, obs_armed);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] s;
    s = 6'b011011;
    load(8'b0110, 4'd4, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(s[5-i], 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    x = 1'b0; x_valid = 1'b1;
    #1;
    total++;
    if ({z, z_q, armed, cfg_err} !== 4'b0000 || match_count !== 8'd0) begin
      bad++;
      $display("FAIL rstmid got=%b cnt=%0d want=0000 cnt=0",
               {z, z_q, armed, cfg_err}, match_count);
    end
    @(negedge clk);
    reset = 1'b0;
    x_valid = 1'b0;
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_z !== 1'b0 || obs_armed !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after z=%b armed=%b want 0 0", obs_z, obs_armed);
    end
  endtask

  task automatic test_reload_mid();
    logic [5:0] s;
    logic w;
    s = 6'b110110;
    load(8'b0110, 4'd4, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (obs_z !== 1'b0) begin
      bad++;
      $display("FAIL reload_z got=%b want=0", obs_z);
    end
    for (int i = 0; i < 6; i++) begin
      w = (i == 5);
      drive(s[5-i], 1'b1, 1'b0, 1'b0);
      total++;
      if (obs_z !== w) begin
        bad++;
        $display("FAIL reload_fill bit%0d got=%b want=%b", i + 1, obs_z, w);
      end
    end
  endtask

  task automatic test_counter();
    load(8'b11, 4'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_cnt2 !== 2'd3 || obs_cnt !== 8'd5) begin
      bad++;
      $display("FAIL cnt_sat got=%0d/%0d want=3/5", obs_cnt2, obs_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (obs_z !== 1'b1) begin
      bad++;
      $display("FAIL cnt_clr_z got=%b want=1", obs_z);
    end
    total++;
    if (obs_cnt2 !== 2'd0 || obs_cnt !== 8'd0) begin
      bad++;
      $display("FAIL cnt_clr got=%0d/%0d want=0/0", obs_cnt2, obs_cnt);
    end
  endtask

  task automatic test_random();
    logic we, clr;
    for (int r = 0; r < 6; r++) begin
      cfg_len = ($urandom % 2) ? 4'($urandom_range(1, 3))
                               : 4'($urandom_range(1, 8));
      cfg_pattern = 8'($urandom);
      cfg_overlap = 1'($urandom % 2);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 200; c++) begin
        we = ($urandom % 60 == 0);
        clr = ($urandom % 40 == 0);
        if (we) begin
          cfg_len = ($urandom % 5 == 0) ? 4'($urandom_range(9, 15)) * 4'($urandom % 2)
                                        : 4'($urandom_range(1, 4));
          cfg_pattern = 8'($urandom);
          cfg_overlap = 1'($urandom % 2);
        end
        drive(1'($urandom % 2), ($urandom % 4 != 0), we, clr);
        total++;
        if (obs_z !== exp_z || obs_z2 !== exp_z) begin
          bad++;
          $display("FAIL rnd_z r%0d c%0d got=%b/%b want=%b",
                   r, c, obs_z, obs_z2, exp_z);
        end
        total++;
        if (obs_zq !== m_zq || obs_zq2 !== m_zq) begin
          bad++;
          $display("FAIL rnd_zq r%0d c%0d got=%b/%b want=%b",
                   r, c, obs_zq, obs_zq2, m_zq);
        end
        total++;
        if (obs_cnt !== 8'(m_cnt) || obs_cnt2 !== 2'(m_cnt2)) begin
          bad++;
          $display("FAIL rnd_cnt r%0d c%0d got=%0d/%0d want=%0d/%0d",
                   r, c, obs_cnt, obs_cnt2, m_cnt, m_cnt2);
        end
        total++;
        if ({obs_armed, obs_err, obs_armed2, obs_err2} !==
            {m_armed, m_err, m_armed, m_err}) begin
          bad++;
          $display("FAIL rnd_cfg r%0d c%0d got=%b%b want=%b%b",
                   r, c, obs_armed, obs_err, m_armed, m_err);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_len_bounds();
    test_bad_cfg();
    test_reset_mid();
    test_reload_mid();
    test_counter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
